// File: rtl/iter_shift_reg_pkg.sv
// Package shift_pkg: shared definitions for the iterative shift unit.
//   - Op code constants. The low two bits keep the meaning of the older
//     load/shift/hold register's select input.
//   - FSM state encoding.
//   - A helper that says whether an op code is a rotate.
// Optional feature macro: ITER_SHIFT_ROTATE_EN enables the rotate ops.
package shift_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_NOP  = 3'b011;
  localparam logic [2:0] OP_SAR  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  function automatic logic is_rotate(input logic [2:0] op);
    return (op == OP_ROR) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/iter_shift_reg_if.sv
// iter_shift_reg_if: command/result bundle between the CPU control unit
// (master) and the shift functional unit (slave).
//   Start    command strobe          Op       operation code
//   Amt      shift count (CW bits)   Data_in  parallel load value
//   Ser_in   serial fill bit         Q        result register
//   Carry_out last bit shifted out   Busy     shifting in progress
//   Done     one-cycle completion pulse
interface iter_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
);

  logic             Start;
  logic [2:0]       Op;
  logic [CW-1:0]    Amt;
  logic [WIDTH-1:0] Data_in;
  logic             Ser_in;
  logic [WIDTH-1:0] Q;
  logic             Carry_out;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Op, Amt, Data_in, Ser_in,
    input  Q, Carry_out, Busy, Done
  );

  modport slave (
    input  Start, Op, Amt, Data_in, Ser_in,
    output Q, Carry_out, Busy, Done
  );

endinterface

// File: rtl/iter_shift_reg_step.sv
// shift_step: combinational one-bit shift/rotate of a WIDTH-bit word.
//   q_i    current register value     op_i  operation code
//   ser_i  fill bit for SHR/SHL
//   q_o    value after one step       out_o bit that left the word
// Rotates exist only when ITER_SHIFT_ROTATE_EN is defined. Otherwise
// they fall to the default arm and are never built.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [2:0]       op_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o,
  output logic             out_o
);

  always_comb begin
    q_o   = q_i;
    out_o = 1'b0;
    case (op_i)
      OP_SHR: begin
        q_o   = {ser_i, q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      OP_SHL: begin
        q_o   = {q_i[WIDTH-2:0], ser_i};
        out_o = q_i[WIDTH-1];
      end
      OP_SAR: begin
        q_o   = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
`ifdef ITER_SHIFT_ROTATE_EN
      OP_ROR: begin
        q_o   = {q_i[0], q_i[WIDTH-1:1]};
        out_o = q_i[0];
      end
      OP_ROL: begin
        q_o   = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
        out_o = q_i[WIDTH-1];
      end
`endif
      default: begin
        q_o   = q_i;
        out_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/iter_shift_reg.sv
// iter_shift_reg: iterative shift functional unit with its own result
// register. One bit position is processed per clock. The unit talks to
// the control unit with a Start/Busy/Done handshake.
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   sif  slave side of iter_shift_reg_if (Start/Op/Amt/Data_in/Ser_in in,
//        Q/Carry_out/Busy/Done out)
// Optional feature macro: ITER_SHIFT_ROTATE_EN. When it is undefined,
// ROR/ROL behave as NOP.
module iter_shift_reg
  import shift_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic              CLK,
  input  logic              RST,
  iter_shift_reg_if.slave   sif
);

  localparam logic [CW-1:0] WIDTH_C = CW'(WIDTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic             shift_cmd;
  logic [CW-1:0]    amt_clamped;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  // Ser_in is taken live on every step. Op is the latched copy, so later
  // changes on the bus have no effect while shifting.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .q_i   (q_q),
    .op_i  (op_q),
    .ser_i (sif.Ser_in),
    .q_o   (step_q),
    .out_o (step_out)
  );

  always_comb begin
    amt_clamped = (sif.Amt > WIDTH_C) ? WIDTH_C : sif.Amt;
  end

  always_comb begin
    shift_cmd = 1'b0;
    case (sif.Op)
      OP_SHR, OP_SHL, OP_SAR: shift_cmd = 1'b1;
`ifdef ITER_SHIFT_ROTATE_EN
      OP_ROR, OP_ROL:         shift_cmd = is_rotate(sif.Op);
`endif
      default:                shift_cmd = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= OP_NOP;
      q_q     <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    q_d     = q_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sif.Start) begin
          if (sif.Op == OP_LOAD) begin
            q_d    = sif.Data_in;
            done_d = 1'b1;
          end else if (shift_cmd && (amt_clamped != '0)) begin
            state_d = ST_SHIFT;
            count_d = amt_clamped;
            op_d    = sif.Op;
          end else begin
            // NOP, disabled rotate, or zero shift count.
            done_d = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        q_d     = step_q;
        carry_d = step_out;
        count_d = count_q - ONE_C;
        if (count_q == ONE_C) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    sif.Q         = q_q;
    sif.Carry_out = carry_q;
    sif.Busy      = (state_q == ST_SHIFT);
    sif.Done      = done_q;
  end

endmodule

// File: tb/tb_iter_shift_reg.sv
// Self-checking bench for iter_shift_reg (WIDTH=8). It runs the directed
// command sequence below. A small behavioural model predicts each result
// and puts it on a queue. A monitor pops the queue on every Done pulse.
module tb_iter_shift_reg;
  import shift_pkg::*;

`ifdef ITER_SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [8:0] exp_q[$];
  logic [7:0] cur_q = 8'h00;
  logic       cur_c = 1'b0;

  always #5 clk = ~clk;

  iter_shift_reg_if #(.WIDTH(8)) sif ();

  iter_shift_reg #(.WIDTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .sif (sif)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: applies the whole command at once.
  task automatic model(input logic [7:0] q, input logic c, input logic [2:0] op,
                       input int amt, input logic [7:0] data, input logic ser,
                       output logic [7:0] qo, output logic co, output int busy);
    int  n;
    bit  sh;
    n    = (amt > 8) ? 8 : amt;
    qo   = q;
    co   = c;
    busy = 0;
    sh   = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) ||
           (ROT_EN && ((op == 3'd5) || (op == 3'd6)));
    if (op == 3'd0) begin
      qo = data;
    end else if (sh && n > 0) begin
      busy = n;
      for (int i = 0; i < n; i++) begin
        case (op)
          3'd1: begin co = qo[0]; qo = {ser, qo[7:1]}; end
          3'd2: begin co = qo[7]; qo = {qo[6:0], ser}; end
          3'd4: begin co = qo[0]; qo = {qo[7], qo[7:1]}; end
          3'd5: begin co = qo[0]; qo = {qo[0], qo[7:1]}; end
          default: begin co = qo[7]; qo = {qo[6:0], qo[7]}; end
        endcase
      end
    end
  endtask

  // Scoreboard monitor. It also checks that Busy and Done are never high together.
  always @(negedge clk) begin
    if (!rst) begin
      check("busy_done_excl", {31'd0, sif.Busy & sif.Done}, 32'd0);
      if (sif.Done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("sb_result", {23'd0, sif.Q, sif.Carry_out}, {23'd0, e});
        end
      end
    end
  end

  // Issue one command and wait, with a bound, for its Done pulse.
  // The command returns at the Done negedge, so a following call
  // starts in the Done cycle. A nonzero intr value raises a stray
  // Start(LOAD 0) at that busy cycle.
  task automatic cmd(input logic [2:0] op, input int amt, input logic [7:0] data,
                     input logic ser, input int intr, input string tag);
    logic [7:0] eq;
    logic       ec;
    int         eb, n, nb;
    model(cur_q, cur_c, op, amt, data, ser, eq, ec, eb);
    exp_q.push_back({eq, ec});
    cur_q = eq;
    cur_c = ec;
    sif.Start   = 1'b1;
    sif.Op      = op;
    sif.Amt     = 4'(amt);
    sif.Data_in = data;
    sif.Ser_in  = ser;
    @(negedge clk);
    sif.Start   = 1'b0;
    sif.Op      = OP_LOAD;
    sif.Amt     = 4'd0;
    sif.Data_in = 8'h00;
    n  = 1;
    nb = 0;
    while (!sif.Done && n < 40) begin
      if (sif.Busy) nb++;
      sif.Start = (intr > 0) && (nb == intr) && sif.Busy;
      @(negedge clk);
      n++;
    end
    sif.Start = 1'b0;
    check({tag, "_done"}, {31'd0, sif.Done}, 32'd1);
    check({tag, "_busy_cycles"}, 32'(nb), 32'(eb));
    check({tag, "_latency"}, 32'(n), 32'(eb + 1));
  endtask

  initial begin
    sif.Start   = 1'b0;
    sif.Op      = OP_NOP;
    sif.Amt     = 4'd0;
    sif.Data_in = 8'h00;
    sif.Ser_in  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_q", {24'd0, sif.Q}, 32'd0);
    check("rst_carry", {31'd0, sif.Carry_out}, 32'd0);
    check("rst_busy", {31'd0, sif.Busy}, 32'd0);
    check("rst_done", {31'd0, sif.Done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // LOAD A5, SHR 3 with zero fill
    cmd(OP_LOAD, 0, 8'hA5, 1'b0, 0, "load_a5");
    check("load_a5_q", {24'd0, sif.Q}, 32'hA5);
    cmd(OP_SHR, 3, 8'h00, 1'b0, 0, "shr3");
    check("shr3_q", {24'd0, sif.Q}, 32'h14);
    check("shr3_c", {31'd0, sif.Carry_out}, 32'd1);
    @(negedge clk);
    check("shr3_done_single", {31'd0, sif.Done}, 32'd0);

    // SAR keeps sign, then SHL by full width with one fill
    cmd(OP_LOAD, 0, 8'h96, 1'b0, 0, "load_96");
    cmd(OP_SAR, 2, 8'h00, 1'b0, 0, "sar2");
    check("sar2_q", {24'd0, sif.Q}, 32'hE5);
    check("sar2_c", {31'd0, sif.Carry_out}, 32'd1);
    cmd(OP_SHL, 8, 8'h00, 1'b1, 0, "shl8");
    check("shl8_q", {24'd0, sif.Q}, 32'hFF);
    check("shl8_c", {31'd0, sif.Carry_out}, 32'd1);

    // ROL 1 (NOP when rotates are not built)
    cmd(OP_LOAD, 0, 8'h81, 1'b0, 0, "load_81");
    cmd(OP_ROL, 1, 8'h00, 1'b0, 0, "rol1");
    check("rol1_q", {24'd0, sif.Q}, ROT_EN ? 32'h03 : 32'h81);

    // Stray Start during SHR 4 is ignored, LOAD in the Done cycle is taken
    cmd(OP_LOAD, 0, 8'h3C, 1'b0, 0, "load_3c");
    cmd(OP_SHR, 4, 8'h00, 1'b0, 2, "shr4_intr");
    check("shr4_intr_q", {24'd0, sif.Q}, 32'h03);
    cmd(OP_LOAD, 0, 8'h5A, 1'b0, 0, "load_in_done");
    check("load_in_done_q", {24'd0, sif.Q}, 32'h5A);

    // Zero count, and a count that clamps to the width
    cmd(OP_SHL, 0, 8'h00, 1'b1, 0, "shl0");
    check("shl0_q", {24'd0, sif.Q}, 32'h5A);
    cmd(OP_SHR, 15, 8'h00, 1'b1, 0, "shr15");
    check("shr15_q", {24'd0, sif.Q}, 32'hFF);
    cmd(OP_SHR, 8, 8'h00, 1'b0, 0, "shr8_zero");
    check("shr8_zero_q", {24'd0, sif.Q}, 32'h00);

    // Full-width rotate returns the original value
    cmd(OP_LOAD, 0, 8'hB4, 1'b0, 0, "load_b4");
    cmd(OP_ROR, 8, 8'h00, 1'b0, 0, "ror8");
    check("ror8_q", {24'd0, sif.Q}, 32'hB4);
    cmd(OP_SAR, 8, 8'h00, 1'b0, 0, "sar8");
    check("sar8_q", {24'd0, sif.Q}, 32'hFF);

    // Reset in the middle of SHR 5
    cmd(OP_LOAD, 0, 8'h77, 1'b0, 0, "load_77");
    sif.Start  = 1'b1;
    sif.Op     = OP_SHR;
    sif.Amt    = 4'd5;
    sif.Ser_in = 1'b0;
    @(negedge clk);
    sif.Start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", {31'd0, sif.Busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_q", {24'd0, sif.Q}, 32'd0);
    check("mid_rst_busy", {31'd0, sif.Busy}, 32'd0);
    check("mid_rst_carry", {31'd0, sif.Carry_out}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    cur_q = 8'h00;
    cur_c = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_done", {31'd0, sif.Done}, 32'd0);
    end
    cmd(OP_LOAD, 0, 8'h12, 1'b0, 0, "load_after_rst");
    check("load_after_rst_q", {24'd0, sif.Q}, 32'h12);
    @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
